// File: rtl/mux4to1_bit.sv
// 4:1 multiplexer slice: combinational AND-OR select path plus a registered
// copy of the result with a valid flag for pipelined consumers.
module mux4to1_bit #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic [WIDTH-1:0] i4,
   input  logic [1:0]       s,
   input  logic             en,
   output logic [WIDTH-1:0] y,
   output logic [3:0]       sel_oh,
   output logic [WIDTH-1:0] y_q,
   output logic             vld
);

   // An unknown select decodes to X so it propagates to y rather than
   // silently picking i1.
   always_comb begin
      sel_oh = 4'b0000;
      case (s)
         2'b00:   sel_oh = 4'b0001;
         2'b01:   sel_oh = 4'b0010;
         2'b10:   sel_oh = 4'b0100;
         2'b11:   sel_oh = 4'b1000;
         default: sel_oh = 4'bxxxx;
      endcase
   end

   always_comb begin
      y = ({WIDTH{sel_oh[0]}} & i1)
        | ({WIDTH{sel_oh[1]}} & i2)
        | ({WIDTH{sel_oh[2]}} & i3)
        | ({WIDTH{sel_oh[3]}} & i4);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q <= '0;
         vld <= 1'b0;
      end else begin
         if (en) begin
            y_q <= y;
         end
         vld <= en;
      end
   end

endmodule

// File: tb/tb_mux4to1_bit.sv
// Bench for mux4to1_bit: a 1-bit and a 4-bit instance share select/control;
// the 1-bit slice sees bit 0 of the 4-bit data.
module tb_mux4to1_bit;

   logic       clk;
   logic       rst_n;
   logic [1:0] s;
   logic       en;
   logic [3:0] d [4];

   logic [3:0] y4, y_q4;
   logic [3:0] sel4, sel1;
   logic       vld4, vld1;
   logic       y1, y_q1;

   int compared   = 0;
   int mismatched = 0;
   bit check_en   = 1'b0;

   // Model state for the registered path
   logic [3:0] m_q   = 4'h0;
   logic       m_vld = 1'b0;

   mux4to1_bit #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .i1(d[0]), .i2(d[1]), .i3(d[2]), .i4(d[3]),
      .s(s), .en(en), .y(y4), .sel_oh(sel4), .y_q(y_q4), .vld(vld4)
   );

   mux4to1_bit dut1 (
      .clk(clk), .rst_n(rst_n), .i1(d[0][0]), .i2(d[1][0]), .i3(d[2][0]),
      .i4(d[3][0]), .s(s), .en(en), .y(y1), .sel_oh(sel1), .y_q(y_q1), .vld(vld1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] ref_mux(input logic [1:0] sel);
      return d[sel];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Registered model: capture selected data on enabled edges, clear on reset.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_q   = 4'h0;
            m_vld = 1'b0;
         end else begin
            if (en) m_q = ref_mux(s);
            m_vld = en;
         end
      end
   end

   // Compare process, away from the active edge
   always @(negedge clk) begin
      if (check_en) begin
         chk("cmp_y4", y4, ref_mux(s));
         chk("cmp_y1", y1, ref_mux(s) & 4'h1);
         chk("cmp_sel4", sel4, 4'b0001 << s);
         chk("cmp_sel1", sel1, 4'b0001 << s);
         chk("cmp_yq4", y_q4, m_q);
         chk("cmp_yq1", y_q1, m_q & 4'h1);
         chk("cmp_vld4", vld4, m_vld);
         chk("cmp_vld1", vld1, m_vld);
      end
   end

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [3:0] lit_y1  [4];
      logic [3:0] lit_sel [4];
      logic [3:0] lit_y4  [4];
      lit_y1  = '{4'h1, 4'h0, 4'h1, 4'h0};
      lit_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      lit_y4  = '{4'h4, 4'h1, 4'h9, 4'h3};

      rst_n = 1'b1;
      en    = 1'b0;
      s     = 2'b00;
      for (int k = 0; k < 4; k++) d[k] = 4'h0;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_yq4", y_q4, 4'h0);
      chk("reset_vld4", vld4, 1'b0);
      check_en = 1'b1;
      step();
      step();
      rst_n = 1'b1;

      // Exhaustive select on the 1-bit slice: 1,0,1,0
      d[0] = 4'h1; d[1] = 4'h0; d[2] = 4'h1; d[3] = 4'h0;
      for (int k = 0; k < 4; k++) begin
         step();
         s = k[1:0];
         #1;
         chk("exh_y1", y1, lit_y1[k]);
         chk("exh_sel1", sel1, lit_sel[k]);
      end

      // Worked 4-bit example
      d[0] = 4'h4; d[1] = 4'h1; d[2] = 4'h9; d[3] = 4'h3;
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         s = k[1:0];
         #1;
         chk("ex_y4", y4, lit_y4[k]);
      end

      // Random data, select sweep; enable toggled to exercise hold
      for (int it = 0; it < 9; it++) begin
         for (int k = 0; k < 4; k++) d[k] = 4'($urandom_range(0, 15));
         for (int k = 0; k < 4; k++) begin
            step();
            s  = k[1:0];
            en = 1'($urandom_range(0, 1));
         end
      end

      // Registered capture then hold
      step();
      en = 1'b1; s = 2'b10;
      for (int k = 0; k < 4; k++) d[k] = 4'h0;
      d[2] = 4'h1;
      step();
      chk("cap_yq1", y_q1, 1'b1);
      chk("cap_vld1", vld1, 1'b1);
      en = 1'b0; d[2] = 4'h0;
      #1;
      chk("hold_y1_now", y1, 1'b0);
      chk("hold_yq1_now", y_q1, 1'b1);
      step();
      chk("hold_yq1", y_q1, 1'b1);
      chk("hold_vld1", vld1, 1'b0);

      // Async reset between edges
      rst_n = 1'b0;
      #1;
      chk("arst_yq1", y_q1, 1'b0);
      chk("arst_vld1", vld1, 1'b0);
      d[2] = 4'h1;
      #1;
      chk("arst_y1_live", y1, 1'b1);

      // Release with en=1, s=3, i4=1
      en = 1'b1; s = 2'b11; d[3] = 4'h1;
      step();
      chk("rel_yq1_held", y_q1, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("rel_yq1_pre", y_q1, 1'b0);
      chk("rel_vld1_pre", vld1, 1'b0);
      step();
      chk("rel_yq1", y_q1, 1'b1);
      chk("rel_vld1", vld1, 1'b1);

      // Unknown select propagates X where the simulator models four states
      #1;
      check_en = 1'b0;
      s = 2'bx1;
      #1;
      if ($isunknown(s)) begin
         chk("xsel_y4", 32'($isunknown(y4)), 32'd1);
         chk("xsel_oh", 32'($isunknown(sel4)), 32'd1);
      end
      s = 2'b01; d[1] = 4'hA;
      #1;
      chk("xsel_recover_y4", y4, 4'hA);
      check_en = 1'b1;
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mux4to1_bit.md
Name: mux4to1_bit

Overview:
- Single-bit 4-to-1 multiplexer, the per-bit slice of the multi-bit 4:1 mux; four instances with a shared select form the 4-bit mux.
- Combinational path: y follows the selected input with zero latency.
- Registered copy of the result plus a valid flag, for pipelined consumers.
- Datapath is an AND-OR structure: select decoded to one-hot, each input ANDed with its decode line, results ORed.

Parameters:
- WIDTH, 1, bit width of each data input and of y/y_q. Default 1 is the slice used by the multi-bit mux; all bits share s.

Ports:
- clk  input  1  rising-edge clock for registered outputs.
- rst_n  input  1  reset; asynchronous, active-low.
- i1  input  WIDTH  data input, selected when s=2'b00.
- i2  input  WIDTH  data input, selected when s=2'b01.
- i3  input  WIDTH  data input, selected when s=2'b10.
- i4  input  WIDTH  data input, selected when s=2'b11.
- s  input  2  select.
- en  input  1  capture enable for registered outputs.
- y  output  WIDTH  combinational mux output.
- sel_oh  output  4  combinational one-hot decode of s; bit k set when s==k.
- y_q  output  WIDTH  registered mux output.
- vld  output  1  registered valid; high when y_q holds a capture from the previous cycle.

Behaviour:
- Combinational path:
  - y = i1 if s=00, i2 if s=01, i3 if s=10, i4 if s=11.
  - y is independent of clk, rst_n and en; it responds within the same delta to changes on any data input or s.
  - sel_oh = 4'b0001 / 0010 / 0100 / 1000 for s = 0 / 1 / 2 / 3.
  - Exactly one sel_oh bit is high for any known s.
  - If s contains X/Z, y and sel_oh are X. No silent default to i1.
- Reset:
  - rst_n low immediately, without waiting for clk, forces y_q=0 and vld=0.
  - Registered outputs hold 0 while rst_n is low.
  - y and sel_oh remain live during reset.
- Registered path, on each rising clk with rst_n high:
  - en=1: y_q <= y (value of the combinational mux just before the edge); vld <= 1.
  - en=0: y_q holds its value; vld <= 0.
  - Latency from input/select change to y_q is one clock edge.
- Reset release: first capture occurs on the first rising edge after rst_n goes high with en=1. Release coinciding with an edge does not capture on that edge.
- Reset mid-operation: y_q and vld clear asynchronously; the combinational output is unaffected.
- Select and data changing together in one cycle: y_q captures the mux of the values present at the edge.
- No state machine. Storage is only the y_q and vld registers.

Test Plan:
- Exhaustive select, WIDTH=1: i1=1, i2=0, i3=1, i4=0; sweep s=0,1,2,3 with 10 time units per step -> y = 1,0,1,0; sel_oh = 0001, 0010, 0100, 1000.
- Randomized, WIDTH=4, 9 iterations: random i1..i4; for each, sweep s=0..3 -> y equals the selected input every step (e.g. i1=4, i2=1, i3=9, i4=3 gives y = 4, 1, 9, 3).
- Registered capture: rst_n=1, en=1, s=2, i3=1 -> after one rising edge y_q=1 and vld=1. Then en=0 and i3=0 -> y goes to 0 immediately; y_q stays 1; vld=0 after the next edge.
- Async reset: with y_q=1, drop rst_n between edges -> y_q=0 and vld=0 immediately; y still tracks the selected input.
- Reset release: raise rst_n with en=1, s=3, i4=1 -> y_q stays 0 until the first subsequent rising edge, then y_q=1 and vld=1.
- X select: s=2'bx1 -> y=X and sel_oh contains X. Then s=2'b01 -> y=i2.
